// File: rtl/fact_arb.sv
// Round-robin front end that time-shares a single fact core between NREQ requesters.
// One operation is in flight at a time: accept, issue go, wait for done/err, then respond.
module fact_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_n,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_nf,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    core_go,
    output logic [WIDTH-1:0]        core_n,
    input  logic                    core_done,
    input  logic                    core_err,
    input  logic [WIDTH-1:0]        core_nf
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW:0] NREQ_EXT = (IDXW+1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  core_n_q, core_n_d;
    logic [WIDTH-1:0]  rsp_nf_q, rsp_nf_d;
    logic              rsp_err_q, rsp_err_d;

    logic [IDXW-1:0]   cand_idx [NREQ];
    logic              sel_found;
    logic [IDXW-1:0]   sel_idx;
    logic [WIDTH-1:0]  sel_n;
    logic [IDXW:0]     gnt_inc;
    logic [IDXW-1:0]   gnt_next;

    // cand_idx[k] is the requester k places after ptr, wrapped modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IDXW:0] sum;
        assign sum          = {1'b0, ptr_q} + (IDXW+1)'(gi);
        assign cand_idx[gi] = (sum >= NREQ_EXT) ? IDXW'(sum - NREQ_EXT) : sum[IDXW-1:0];
    end

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx[k];
            end
        end
        sel_n = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDXW'(i)) begin
                sel_n = req_n[i*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt_inc  = {1'b0, gnt_q} + (IDXW+1)'(1);
    assign gnt_next = (gnt_inc >= NREQ_EXT) ? '0 : gnt_inc[IDXW-1:0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        core_n_d  = core_n_q;
        rsp_nf_d  = rsp_nf_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    core_n_d = sel_n;
                    gnt_d    = sel_idx;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // An error flag overrides a simultaneous done and forces a zero result.
                if (core_done || core_err) begin
                    rsp_err_d = core_err;
                    rsp_nf_d  = core_err ? '0 : core_nf;
                    state_d   = RESP;
                end
            end
            RESP: begin
                ptr_d   = gnt_next;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            core_n_q  <= '0;
            rsp_nf_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            core_n_q  <= core_n_d;
            rsp_nf_q  <= rsp_nf_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_strobe
        assign req_ready[gi] = (state_q == IDLE) && sel_found && (sel_idx == IDXW'(gi));
        assign rsp_valid[gi] = (state_q == RESP) && (gnt_q == IDXW'(gi));
    end

    // Result outputs are held at zero outside RESP so idle bus reads are clean.
    assign rsp_nf  = (state_q == RESP) ? rsp_nf_q : '0;
    assign rsp_err = (state_q == RESP) ? rsp_err_q : 1'b0;
    assign busy    = (state_q != IDLE);
    assign core_go = (state_q == ISSUE);
    assign core_n  = core_n_q;

endmodule

// File: tb/tb_fact_arb.sv
// Directed plus randomized bench for fact_arb with a behavioural fact core stub
// whose latency and error behaviour are set per operation.
module tb_fact_arb;
    localparam int WIDTH = 32;
    localparam int NREQ  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_n;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_nf;
    logic                  rsp_err;
    logic                  busy;
    logic                  core_go;
    logic [WIDTH-1:0]      core_n;
    logic                  core_done;
    logic                  core_err;
    logic [WIDTH-1:0]      core_nf;

    fact_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_nf    (rsp_nf),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .core_go   (core_go),
        .core_n    (core_n),
        .core_done (core_done),
        .core_err  (core_err),
        .core_nf   (core_nf)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = 0;

    // n! in WIDTH bits; bit 32 flags overflow.
    function automatic logic [32:0] fact_ref(input logic [31:0] n);
        logic [63:0] acc;
        bit          ovf;
        acc = 64'd1;
        ovf = 1'b0;
        if (n > 32'd20) ovf = 1'b1;
        for (int unsigned i = 2; i <= n && !ovf; i++) begin
            acc = acc * 64'(i);
            if (acc > 64'hFFFF_FFFF) ovf = 1'b1;
        end
        return ovf ? {1'b1, 32'h0} : {1'b0, acc[31:0]};
    endfunction

    // Stub core: flag appears stub_lat cycles after the cycle following go.
    int          stub_lat  = 1;
    bit          stub_both = 1'b0;
    int          stub_cnt  = 0;
    logic [31:0] stub_n    = '0;
    logic [32:0] stub_res;
    assign stub_res = fact_ref(stub_n);

    always @(posedge clk) begin
        if (rst) begin
            stub_cnt  <= 0;
            core_done <= 1'b0;
            core_err  <= 1'b0;
            core_nf   <= '0;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            core_nf   <= '0;
            if (core_go) begin
                stub_cnt <= stub_lat;
                stub_n   <= core_n;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    if (stub_both) begin
                        core_done <= 1'b1;
                        core_err  <= 1'b1;
                        core_nf   <= 32'hDEAD_BEEF;
                    end else if (stub_res[32]) begin
                        core_err  <= 1'b1;
                        core_nf   <= 32'hDEAD_BEEF;
                    end else begin
                        core_done <= 1'b1;
                        core_nf   <= stub_res[31:0];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] n);
        req_valid[i]             = 1'b1;
        req_n[i*WIDTH +: WIDTH]  = n;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_core_n", core_n, 0);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // One full transaction from the accept cycle to the first IDLE cycle after RESP.
    task automatic serve(input int lat, input bit hold, input int raise_idx,
                         input logic [31:0] raise_n, input bit both,
                         output int g, output int t_acc, output int t_rsp);
        logic [31:0]     n_exp;
        logic [32:0]     r;
        logic [NREQ-1:0] oh;
        int              k;
        #1;
        stub_lat  = lat;
        stub_both = both;
        g     = pick(req_valid);
        oh    = NREQ'(1) << g;
        n_exp = req_n[g*WIDTH +: WIDTH];
        r     = both ? {1'b1, 32'h0} : fact_ref(n_exp);
        check("accept_ready", req_ready, oh);
        check("accept_busy", busy, 0);
        t_acc = cycle;
        @(posedge clk); #1;
        if (!hold) req_valid[g] = 1'b0;
        check("issue_go", core_go, 1);
        check("issue_core_n", core_n, n_exp);
        check("issue_ready", req_ready, 0);
        if (raise_idx >= 0) set_req(raise_idx, raise_n);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (rsp_valid == 0) begin
                check("wait_go", core_go, 0);
                check("wait_ready", req_ready, 0);
                check("wait_core_n", core_n, n_exp);
            end
        end while (rsp_valid == 0 && k < 300);
        t_rsp = cycle;
        check("rsp_latency", 64'(t_rsp - t_acc), 64'(3 + lat));
        check("rsp_valid", rsp_valid, oh);
        check("rsp_nf", rsp_nf, r[31:0]);
        check("rsp_err", rsp_err, r[32]);
        check("rsp_ready", req_ready, 0);
        m_ptr = (g + 1) % NREQ;
        @(posedge clk); #1;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        stub_both = 1'b0;
    endtask

    initial begin
        int g, ta, tr, prev_tr;
        rst = 1'b1;
        req_valid = '0;
        req_n = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_go", core_go, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_nf", rsp_nf, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_core_n", core_n, 0);
        rst = 1'b0;
        m_ptr = 0;

        // Single request, then error path followed by a clean operation.
        set_req(0, 5);
        serve(4, 1'b0, -1, 0, 1'b0, g, ta, tr);
        check("single_grant", g, 0);
        set_req(1, 13);
        serve(3, 1'b0, -1, 0, 1'b0, g, ta, tr);
        check("err_grant", g, 1);
        set_req(1, 3);
        serve(2, 1'b0, -1, 0, 1'b0, g, ta, tr);

        // Simultaneous requests held valid: order 0,1,0,1 with back-to-back accepts.
        do_reset();
        set_req(0, 4);
        set_req(1, 6);
        prev_tr = -1;
        for (int i = 0; i < 4; i++) begin
            serve(1 + i, 1'b1, -1, 0, 1'b0, g, ta, tr);
            check("rr_order", g, i % 2);
            if (prev_tr >= 0) check("rr_accept_gap", 64'(ta - prev_tr), 1);
            prev_tr = tr;
        end
        req_valid = '0;
        @(posedge clk); #1;

        // Backpressure: requester 0 raises while requester 1 is in flight.
        set_req(1, 7);
        serve(5, 1'b0, 0, 8, 1'b0, g, ta, tr);
        check("bp_first_grant", g, 1);
        prev_tr = tr;
        serve(2, 1'b0, -1, 0, 1'b0, g, ta, tr);
        check("bp_second_grant", g, 0);
        check("bp_accept_gap", 64'(ta - prev_tr), 1);

        // Reset while waiting on a long n=10 operation.
        set_req(1, 10);
        #1;
        stub_lat = 20;
        check("mid_accept", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = '0;
        check("mid_go", core_go, 1);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_go", core_go, 0);
        check("mid_rst_rsp", {rsp_valid, rsp_err, rsp_nf}, 0);
        check("mid_rst_core_n", core_n, 0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check("mid_quiet", {rsp_valid, busy}, 0);
        end
        set_req(0, 2);
        set_req(1, 9);
        serve(2, 1'b0, -1, 0, 1'b0, g, ta, tr);
        check("mid_ptr_cleared", g, 0);
        serve(3, 1'b0, -1, 0, 1'b0, g, ta, tr);

        // Fixed latency 7: response exactly 10 cycles after accept.
        set_req(0, 6);
        serve(7, 1'b0, -1, 0, 1'b0, g, ta, tr);
        check("lat7_total", 64'(tr - ta), 10);

        // Error overrides a simultaneous done.
        set_req(1, 4);
        serve(3, 1'b0, -1, 0, 1'b1, g, ta, tr);

        // Randomized mix of requesters, operands, latencies and error overrides.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 32'($urandom_range(0, 14)));
            end
            if (req_valid == '0)
                set_req(int'($urandom_range(0, NREQ - 1)), 32'($urandom_range(0, 14)));
            serve(int'($urandom_range(1, 6)), 1'b0, -1, 0,
                  $urandom_range(0, 7) == 0, g, ta, tr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
